// File: rtl/oled_spi_rx.sv
// Receive side of the PmodOLED SPI link: rebuilds SSD1331 command bytes and
// RGB565 pixel writes (with framebuffer address) from the cs/sdin/sclk/d_cn/resn pins.
module oled_spi_rx #(
  parameter int WIDTH  = 96,
  parameter int HEIGHT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        sdin,
  input  logic        sclk,
  input  logic        d_cn,
  input  logic        resn,
  output logic        cmd_valid,
  output logic [7:0]  cmd_byte,
  output logic        pix_we,
  output logic [12:0] pix_addr,
  output logic [15:0] pix_data,
  output logic        frame_done,
  output logic        proto_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_COL_A = 3'd1;
  localparam logic [2:0] S_COL_B = 3'd2;
  localparam logic [2:0] S_ROW_A = 3'd3;
  localparam logic [2:0] S_ROW_B = 3'd4;

  localparam logic [7:0]  COL_MAX    = 8'(WIDTH - 1);
  localparam logic [7:0]  ROW_MAX    = 8'(HEIGHT - 1);
  localparam logic [12:0] ROW_STRIDE = 13'(WIDTH);
  localparam logic [4:0]  PINS_IDLE  = 5'b10001;

  // ---------------------------------------------------------------------------
  // Pin synchronizers, bit order {resn, d_cn, sclk, sdin, cs}
  // ---------------------------------------------------------------------------
  logic [4:0] sync_a;
  logic [4:0] sync_b;
  logic       cs_s, sdin_s, sclk_s, dcn_s, resn_s;
  logic       sclk_d, cs_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a <= PINS_IDLE;
      sync_b <= PINS_IDLE;
      sclk_d <= 1'b0;
      cs_d   <= 1'b1;
    end else begin
      sync_a <= {resn, d_cn, sclk, sdin, cs};
      sync_b <= sync_a;
      sclk_d <= sclk_s;
      cs_d   <= cs_s;
    end
  end

  assign cs_s   = sync_b[0];
  assign sdin_s = sync_b[1];
  assign sclk_s = sync_b[2];
  assign dcn_s  = sync_b[3];
  assign resn_s = sync_b[4];

  // ---------------------------------------------------------------------------
  // Byte assembler
  // ---------------------------------------------------------------------------
  logic       sclk_rise;
  logic       take_bit;
  logic [2:0] bit_cnt;
  logic [6:0] shift;
  logic       byte_valid;
  logic [7:0] rx_byte;
  logic       rx_dc;

  // An 8th edge arriving together with cs rising still completes its byte.
  assign sclk_rise = sclk_s & ~sclk_d;
  assign take_bit  = sclk_rise & (~cs_s | ((bit_cnt == 3'd7) & ~cs_d));

  always_ff @(posedge clk) begin
    if (reset || !resn_s) begin
      bit_cnt    <= '0;
      shift      <= '0;
      byte_valid <= 1'b0;
      rx_byte    <= '0;
      rx_dc      <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      if (take_bit) begin
        shift <= {shift[5:0], sdin_s};
        if (bit_cnt == 3'd7) begin
          byte_valid <= 1'b1;
          rx_byte    <= {shift, sdin_s};
          rx_dc      <= dcn_s;
          bit_cnt    <= '0;
        end else begin
          bit_cnt <= bit_cnt + 3'd1;
        end
      end else if (cs_s) begin
        bit_cnt <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Command parser, window and cursor
  // ---------------------------------------------------------------------------
  logic [2:0]  state;
  logic [7:0]  arg_lo;
  logic [7:0]  col_start, col_end, row_start, row_end;
  logic [7:0]  cur_col, cur_row;
  logic        phase;
  logic [7:0]  hi_byte;
  logic [7:0]  arg_lim;
  logic [7:0]  arg_clamped;
  logic [7:0]  arg_end;
  logic [12:0] cur_addr;

  always_comb begin
    arg_lim     = ROW_MAX;
    if (state == S_COL_A || state == S_COL_B) arg_lim = COL_MAX;
    arg_clamped = (rx_byte > arg_lim) ? arg_lim : rx_byte;
    arg_end     = (arg_clamped < arg_lo) ? arg_lo : arg_clamped;
    cur_addr    = 13'(cur_row) * ROW_STRIDE + 13'(cur_col);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      arg_lo     <= '0;
      col_start  <= '0;
      col_end    <= COL_MAX;
      row_start  <= '0;
      row_end    <= ROW_MAX;
      cur_col    <= '0;
      cur_row    <= '0;
      phase      <= 1'b0;
      hi_byte    <= '0;
      cmd_valid  <= 1'b0;
      cmd_byte   <= '0;
      pix_we     <= 1'b0;
      pix_addr   <= '0;
      pix_data   <= '0;
      frame_done <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      cmd_valid  <= 1'b0;
      pix_we     <= 1'b0;
      frame_done <= 1'b0;
      proto_err  <= 1'b0;
      if (!resn_s) begin
        state     <= S_IDLE;
        col_start <= '0;
        col_end   <= COL_MAX;
        row_start <= '0;
        row_end   <= ROW_MAX;
        cur_col   <= '0;
        cur_row   <= '0;
        phase     <= 1'b0;
      end else if (byte_valid && !rx_dc) begin
        cmd_valid <= 1'b1;
        cmd_byte  <= rx_byte;
        case (state)
          S_IDLE: begin
            if (rx_byte == 8'h15) state <= S_COL_A;
            else if (rx_byte == 8'h75) state <= S_ROW_A;
          end
          S_COL_A, S_ROW_A: begin
            arg_lo <= arg_clamped;
            state  <= (state == S_COL_A) ? S_COL_B : S_ROW_B;
          end
          S_COL_B: begin
            col_start <= arg_lo;
            col_end   <= arg_end;
            cur_col   <= arg_lo;
            cur_row   <= row_start;
            phase     <= 1'b0;
            state     <= S_IDLE;
          end
          S_ROW_B: begin
            row_start <= arg_lo;
            row_end   <= arg_end;
            cur_col   <= col_start;
            cur_row   <= arg_lo;
            phase     <= 1'b0;
            state     <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end else if (byte_valid) begin
        // A data byte inside an argument sequence aborts it but is still pixel data.
        if (state != S_IDLE) begin
          proto_err <= 1'b1;
          state     <= S_IDLE;
        end
        if (!phase) begin
          hi_byte <= rx_byte;
          phase   <= 1'b1;
        end else begin
          pix_we   <= 1'b1;
          pix_data <= {hi_byte, rx_byte};
          pix_addr <= cur_addr;
          phase    <= 1'b0;
          if (cur_col == col_end) begin
            cur_col <= col_start;
            if (cur_row == row_end) begin
              cur_row    <= row_start;
              frame_done <= 1'b1;
            end else begin
              cur_row <= cur_row + 8'd1;
            end
          end else begin
            cur_col <= cur_col + 8'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_oled_spi_rx.sv
// Self-checking bench for oled_spi_rx: bit-banged SPI stimulus against a
// window/pixel-index model of the display protocol.
module tb_oled_spi_rx;
  localparam int W = 96;
  localparam int H = 64;

  logic        clk = 1'b0;
  logic        reset, cs, sdin, sclk, d_cn, resn;
  logic        cmd_valid, pix_we, frame_done, proto_err;
  logic [7:0]  cmd_byte;
  logic [12:0] pix_addr;
  logic [15:0] pix_data;

  oled_spi_rx #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .reset(reset), .cs(cs), .sdin(sdin), .sclk(sclk), .d_cn(d_cn),
    .resn(resn), .cmd_valid(cmd_valid), .cmd_byte(cmd_byte), .pix_we(pix_we),
    .pix_addr(pix_addr), .pix_data(pix_data), .frame_done(frame_done),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
    bit fd;
  } pix_t;

  int checks = 0;
  int errors = 0;

  byte unsigned obs_cmd[$];
  longint       obs_cmd_t[$];
  pix_t         obs_pix[$];
  int           obs_proto;
  int           stray_fd;
  longint       last_rise;

  byte unsigned exp_cmd[$];
  pix_t         exp_pix[$];
  int           exp_proto;

  // model: window bounds, linear pixel index inside the window, pending command + args
  int m_cs, m_ce, m_rs, m_re, m_k, m_hi, m_pend;
  bit m_hi_ok;
  int m_args[$];

  always @(negedge clk) begin
    if (cmd_valid) begin
      obs_cmd.push_back(cmd_byte);
      obs_cmd_t.push_back($time - last_rise);
    end
    if (pix_we) begin
      pix_t p;
      p.addr = int'(pix_addr);
      p.data = int'(pix_data);
      p.fd   = frame_done;
      obs_pix.push_back(p);
    end
    if (proto_err) obs_proto++;
    if (frame_done && !pix_we) stray_fd++;
  end

  function automatic void model_reset();
    m_cs = 0; m_ce = W - 1; m_rs = 0; m_re = H - 1;
    m_k = 0; m_hi_ok = 0; m_pend = -1;
    m_args.delete();
  endfunction

  function automatic void model_byte(int b, bit dc);
    if (!dc) begin
      exp_cmd.push_back(8'(b));
      if (m_pend < 0) begin
        if (b == 'h15 || b == 'h75) begin
          m_pend = b;
          m_args.delete();
        end
      end else begin
        m_args.push_back(b);
        if (m_args.size() == 2) begin
          int lim = (m_pend == 'h15) ? W - 1 : H - 1;
          int s = (m_args[0] > lim) ? lim : m_args[0];
          int e = (m_args[1] > lim) ? lim : m_args[1];
          if (e < s) e = s;
          if (m_pend == 'h15) begin m_cs = s; m_ce = e; end
          else begin m_rs = s; m_re = e; end
          m_k = 0; m_hi_ok = 0; m_pend = -1;
        end
      end
    end else begin
      if (m_pend >= 0) begin
        exp_proto++;
        m_pend = -1;
      end
      if (!m_hi_ok) begin
        m_hi = b;
        m_hi_ok = 1;
      end else begin
        int wc = m_ce - m_cs + 1;
        int n = wc * (m_re - m_rs + 1);
        pix_t p;
        p.addr = (m_rs + m_k / wc) * W + m_cs + m_k % wc;
        p.data = m_hi * 256 + b;
        p.fd   = (m_k == n - 1);
        exp_pix.push_back(p);
        m_k = (m_k + 1) % n;
        m_hi_ok = 0;
      end
    end
  endfunction

  task automatic flush();
    obs_cmd.delete(); obs_cmd_t.delete(); obs_pix.delete();
    exp_cmd.delete(); exp_pix.delete();
    obs_proto = 0; exp_proto = 0; stray_fd = 0;
  endtask

  task automatic settle();
    repeat (12) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic dc,
                           input bit hold_cs = 0, input bit cs_at_last = 0);
    @(negedge clk);
    cs = 1'b0; d_cn = dc; #20;
    for (int i = 7; i >= 0; i--) begin
      sdin = b[i]; #40;
      if (i == 0 && cs_at_last) cs = 1'b1;
      sclk = 1'b1;
      if (i == 0) last_rise = $time;
      #40;
      sclk = 1'b0;
    end
    if (!hold_cs) begin
      #20; cs = 1'b1; #20;
    end
    if (resn) model_byte(int'(b), dc);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({cmd_valid, cmd_byte, pix_we, pix_addr, pix_data, frame_done, proto_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %b_%h_%b_%h_%h_%b_%b expected all zero",
               cmd_valid, cmd_byte, pix_we, pix_addr, pix_data, frame_done, proto_err);
    end
    reset = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if ({cmd_valid, cmd_byte, pix_we, pix_addr, pix_data, frame_done, proto_err} !== '0) begin
      errors++;
      $display("FAIL post_reset_outputs: got %b_%h_%b_%h_%h_%b_%b expected all zero",
               cmd_valid, cmd_byte, pix_we, pix_addr, pix_data, frame_done, proto_err);
    end
    model_reset();
    flush();
    send_byte(8'hF8, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h07, 1'b1, 1);
    send_byte(8'hE0, 1'b1);
    settle();
    checks++;
    if (obs_pix.size() !== 2) begin
      errors++;
      $display("FAIL reset_pix_count: got %0d expected 2", obs_pix.size());
    end else begin
      checks++;
      if (obs_pix[0].addr !== 0 || obs_pix[0].data !== 'hF800 || obs_pix[0].fd !== 1'b0) begin
        errors++;
        $display("FAIL reset_pix0: got addr %0d data %h expected addr 0 data f800",
                 obs_pix[0].addr, obs_pix[0].data);
      end
      checks++;
      if (obs_pix[1].addr !== 1 || obs_pix[1].data !== 'h07E0) begin
        errors++;
        $display("FAIL reset_pix1: got addr %0d data %h expected addr 1 data 07e0",
                 obs_pix[1].addr, obs_pix[1].data);
      end
    end
  endtask

  task automatic test_window();
    int want_addr[7] = '{496, 497, 498, 592, 593, 594, 496};
    byte unsigned want_cmd[6] = '{8'h15, 8'h10, 8'h12, 8'h75, 8'h05, 8'h06};
    flush();
    foreach (want_cmd[i]) send_byte(want_cmd[i], 1'b0);
    for (int i = 0; i < 14; i++) send_byte(8'($urandom), 1'b1, ($urandom % 2) == 1);
    settle();
    checks++;
    if (obs_cmd.size() !== 6) begin
      errors++;
      $display("FAIL win_cmd_count: got %0d expected 6", obs_cmd.size());
    end
    foreach (want_cmd[i]) if (i < obs_cmd.size()) begin
      checks++;
      if (obs_cmd[i] !== want_cmd[i] || obs_cmd_t[i] !== 40) begin
        errors++;
        $display("FAIL win_cmd[%0d]: got %h after %0d expected %h after 40",
                 i, obs_cmd[i], obs_cmd_t[i], want_cmd[i]);
      end
    end
    checks++;
    if (obs_pix.size() !== 7) begin
      errors++;
      $display("FAIL win_pix_count: got %0d expected 7", obs_pix.size());
    end
    foreach (want_addr[i]) if (i < obs_pix.size() && i < exp_pix.size()) begin
      checks++;
      if (obs_pix[i].addr !== want_addr[i] || obs_pix[i].fd !== (i == 5) ||
          obs_pix[i].data !== exp_pix[i].data) begin
        errors++;
        $display("FAIL win_pix[%0d]: got addr %0d data %h fd %0d expected addr %0d data %h fd %0d",
                 i, obs_pix[i].addr, obs_pix[i].data, obs_pix[i].fd,
                 want_addr[i], exp_pix[i].data, i == 5);
      end
    end
  endtask

  task automatic test_clamp();
    flush();
    send_byte(8'h15, 1'b0); send_byte(8'h70, 1'b0); send_byte(8'h80, 1'b0);
    send_byte(8'h75, 1'b0); send_byte(8'h20, 1'b0); send_byte(8'h10, 1'b0);
    send_byte(8'h5A, 1'b1); send_byte(8'hC3, 1'b1);
    settle();
    checks++;
    if (obs_pix.size() !== 1 || obs_cmd.size() !== 6) begin
      errors++;
      $display("FAIL clamp_counts: got %0d pix %0d cmd expected 1 pix 6 cmd",
               obs_pix.size(), obs_cmd.size());
    end else begin
      checks++;
      if (obs_pix[0].addr !== 3167 || obs_pix[0].data !== 'h5AC3 || obs_pix[0].fd !== 1'b1) begin
        errors++;
        $display("FAIL clamp_pix: got addr %0d data %h fd %0d expected addr 3167 data 5ac3 fd 1",
                 obs_pix[0].addr, obs_pix[0].data, obs_pix[0].fd);
      end
    end
  endtask

  task automatic test_partial();
    flush();
    @(negedge clk);
    cs = 1'b0; d_cn = 1'b0; #20;
    for (int i = 0; i < 5; i++) begin
      sdin = 1'($urandom); #40;
      sclk = 1'b1; #40;
      sclk = 1'b0;
    end
    #20; cs = 1'b1; #40;
    send_byte(8'hA5, 1'b0);
    settle();
    checks++;
    if (obs_cmd.size() !== 1) begin
      errors++;
      $display("FAIL partial_count: got %0d expected 1", obs_cmd.size());
    end else begin
      checks++;
      if (obs_cmd[0] !== 8'hA5) begin
        errors++;
        $display("FAIL partial_byte: got %h expected a5", obs_cmd[0]);
      end
    end
  endtask

  task automatic test_cs_edge();
    flush();
    send_byte(8'hE3, 1'b0, 0, 1);
    settle();
    checks++;
    if (obs_cmd.size() !== 1 || (obs_cmd.size() == 1 && obs_cmd[0] !== 8'hE3)) begin
      errors++;
      $display("FAIL cs_edge: got %0d bytes first %h expected 1 byte e3",
               obs_cmd.size(), obs_cmd.size() > 0 ? obs_cmd[0] : 8'h00);
    end
  endtask

  task automatic test_proto();
    flush();
    send_byte(8'h15, 1'b0); send_byte(8'h10, 1'b0);
    send_byte(8'hAB, 1'b1); send_byte(8'hCD, 1'b1);
    send_byte(8'h12, 1'b1); send_byte(8'h75, 1'b0); send_byte(8'h34, 1'b1);
    settle();
    checks++;
    if (obs_proto !== 2) begin
      errors++;
      $display("FAIL proto_count: got %0d expected 2", obs_proto);
    end
    checks++;
    if (obs_pix.size() !== 2) begin
      errors++;
      $display("FAIL proto_pix_count: got %0d expected 2", obs_pix.size());
    end else begin
      checks++;
      if (obs_pix[0].addr !== 3167 || obs_pix[0].data !== 'hABCD) begin
        errors++;
        $display("FAIL proto_pix0: got addr %0d data %h expected addr 3167 data abcd",
                 obs_pix[0].addr, obs_pix[0].data);
      end
      checks++;
      if (obs_pix[1].addr !== exp_pix[1].addr || obs_pix[1].data !== 'h1234) begin
        errors++;
        $display("FAIL proto_pix1: got addr %0d data %h expected addr %0d data 1234",
                 obs_pix[1].addr, obs_pix[1].data, exp_pix[1].addr);
      end
    end
  endtask

  task automatic test_resn();
    flush();
    send_byte(8'h15, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h5F, 1'b0);
    send_byte(8'h75, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h3F, 1'b0);
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), 1'b1);
    settle();
    resn = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    send_byte(8'h15, 1'b0); send_byte(8'h55, 1'b1); send_byte(8'h66, 1'b1);
    repeat (4) @(negedge clk);
    resn = 1'b1;
    repeat (6) @(negedge clk);
    send_byte(8'h1F, 1'b1); send_byte(8'h2E, 1'b1);
    settle();
    checks++;
    if (obs_cmd.size() !== 6 || obs_pix.size() !== 4) begin
      errors++;
      $display("FAIL resn_counts: got %0d cmd %0d pix expected 6 cmd 4 pix",
               obs_cmd.size(), obs_pix.size());
    end else begin
      checks++;
      if (obs_pix[2].addr !== 2 || obs_pix[3].addr !== 0 || obs_pix[3].data !== 'h1F2E) begin
        errors++;
        $display("FAIL resn_pix: got addr %0d then %0d data %h expected addr 2 then 0 data 1f2e",
                 obs_pix[2].addr, obs_pix[3].addr, obs_pix[3].data);
      end
    end
  endtask

  task automatic test_back_to_back();
    flush();
    for (int it = 0; it < 8; it++) begin
      int npix = int'($urandom_range(1, 14));
      if ($urandom % 2 == 1) begin
        send_byte(8'h15, 1'b0, 1);
        send_byte(8'($urandom_range(0, 120)), 1'b0, 1);
        send_byte(8'($urandom_range(0, 120)), 1'b0, 1);
      end
      if ($urandom % 2 == 1) begin
        send_byte(8'h75, 1'b0, 1);
        send_byte(8'($urandom_range(0, 80)), 1'b0, 1);
        send_byte(8'($urandom_range(0, 80)), 1'b0, 1);
      end
      if ($urandom % 4 == 0) send_byte(8'hAF, 1'b0, 1);
      if ($urandom % 4 == 0) begin
        send_byte(8'h75, 1'b0, 1);
        send_byte(8'($urandom), 1'b1, 1);
      end
      for (int i = 0; i < 2 * npix; i++) send_byte(8'($urandom), 1'b1, ($urandom % 4) != 0);
    end
    send_byte(8'h00, 1'b0);
    settle();
    checks++;
    if (obs_cmd.size() !== exp_cmd.size() || obs_pix.size() !== exp_pix.size() ||
        obs_proto !== exp_proto || stray_fd !== 0) begin
      errors++;
      $display("FAIL b2b_counts: got cmd %0d pix %0d err %0d stray %0d expected cmd %0d pix %0d err %0d stray 0",
               obs_cmd.size(), obs_pix.size(), obs_proto, stray_fd,
               exp_cmd.size(), exp_pix.size(), exp_proto);
    end
    foreach (exp_cmd[i]) if (i < obs_cmd.size()) begin
      checks++;
      if (obs_cmd[i] !== exp_cmd[i]) begin
        errors++;
        $display("FAIL b2b_cmd[%0d]: got %h expected %h", i, obs_cmd[i], exp_cmd[i]);
      end
    end
    foreach (exp_pix[i]) if (i < obs_pix.size()) begin
      checks++;
      if (obs_pix[i].addr !== exp_pix[i].addr || obs_pix[i].data !== exp_pix[i].data ||
          obs_pix[i].fd !== exp_pix[i].fd) begin
        errors++;
        $display("FAIL b2b_pix[%0d]: got addr %0d data %h fd %0d expected addr %0d data %h fd %0d",
                 i, obs_pix[i].addr, obs_pix[i].data, obs_pix[i].fd,
                 exp_pix[i].addr, exp_pix[i].data, exp_pix[i].fd);
      end
    end
  endtask

  initial begin
    reset = 1'b1; cs = 1'b1; sdin = 1'b0; sclk = 1'b0; d_cn = 1'b0; resn = 1'b1;
    last_rise = 0;
    model_reset();
    flush();
    test_reset();
    test_window();
    test_clamp();
    test_partial();
    test_cs_edge();
    test_proto();
    test_resn();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/oled_spi_rx.md
# oled_spi_rx

Receiving end of the PmodOLED SPI link that `Oled_Display` drives onto JA. It decodes cs/sdin/sclk/d_cn/resn into SSD1331 command bytes and RGB565 pixel writes with framebuffer addresses. It is used as an on-board display mirror (pixel writes feed a 96x64 RAM) and as the bench-side display model for maze and other screen blocks.

## Interface
Parameters:
- `WIDTH`, 96: display columns; column arguments are clamped to WIDTH-1.
- `HEIGHT`, 64: display rows; row arguments are clamped to HEIGHT-1.

Ports:
- `clk` in 1: system clock (100 MHz); must be at least 4x the sclk frequency.
- `reset` in 1: synchronous, active-high.
- `cs` in 1: chip select from JA[0], active-low, asynchronous to `clk`.
- `sdin` in 1: serial data from JA[1], MSB first.
- `sclk` in 1: serial clock from JA[3]; data is sampled on its rising edge.
- `d_cn` in 1: JA[4]; 0 = command or argument byte, 1 = data byte.
- `resn` in 1: JA[5], display reset, active-low.
- `cmd_valid` out 1: one-cycle pulse per command or argument byte received.
- `cmd_byte` out 8: the byte reported with `cmd_valid`.
- `pix_we` out 1: one-cycle pulse per completed pixel.
- `pix_addr` out 13: row*WIDTH+col of the pixel.
- `pix_data` out 16: RGB565 value, first byte in bits [15:8].
- `frame_done` out 1: pulse coinciding with `pix_we` for the last pixel of the window.
- `proto_err` out 1: pulse when an argument sequence is broken.

## Operation
- All five inputs pass through 2-FF synchronizers. An sclk rising edge is detected from the synchronized value and its registered copy.
- Bit counter (0-7):
  - Increments on each detected sclk rise while the synchronized cs is 0; the synchronized sdin is shifted in MSB first.
  - cs high clears the bit counter and discards any partial byte.
  - Byte-level state (pixel phase, argument state, cursor) is kept across cs high.
- Byte complete on the 8th bit. d_cn is sampled on that same edge.
- Parser FSM states: IDLE, COL_A, COL_B, ROW_A, ROW_B.
  - IDLE, command byte: 0x15 goes to COL_A; 0x75 goes to ROW_A; any other byte stays in IDLE.
  - COL_A/ROW_A, command byte: captured as the start value, clamped; go to COL_B/ROW_B.
  - COL_B/ROW_B, command byte: captured as the end value, clamped. If end < start, end := start. Window register updates; cursor moves to (col_start, row_start); pixel phase clears; return to IDLE.
  - Any argument state, data byte: `proto_err` pulses, the partial argument is dropped, the window is unchanged, return to IDLE. That data byte is processed as pixel data.
  - `cmd_valid`/`cmd_byte` fire for every byte with d_cn=0, including arguments.
- Pixel path (d_cn=1):
  - Phase 0: store the byte as the high half; phase becomes 1.
  - Phase 1: pulse `pix_we` with `pix_data` = {high, byte} and `pix_addr` at the cursor; phase becomes 0.
  - Cursor advance: col++. When col == col_end, col := col_start and row++. When row == row_end as well, row := row_start and `frame_done` pulses.
- resn low (synchronized) or reset:
  - Window becomes 0..WIDTH-1 / 0..HEIGHT-1.
  - Cursor goes to (0,0); phase, bit counter and FSM clear.
  - No bytes are accepted while resn is low.
- Address arithmetic: row*WIDTH+col computed in 13 bits; the maximum value is 6143.

## Timing
- Reset values: all pulse outputs 0, `cmd_byte` 0, `pix_addr` 0, `pix_data` 0, FSM IDLE.
- Let N be the clk cycle in which the first synchronizer flop captures the 8th sclk rise of a byte. `cmd_valid` or `pix_we` is asserted in cycle N+3, for exactly one cycle. Data outputs hold their value until the next pulse.
- The window/cursor update from a final argument byte takes effect in N+3. A data byte whose 8th edge arrives any later uses the new window.
- Simultaneous events:
  - reset beats resn, which beats byte completion.
  - cs rising in the same cycle as the 8th edge still completes the byte.
  - `proto_err` and `pix_we` may pulse in the same cycle.
- Throughput: one byte per 8 sclk periods, no back-pressure.

## Test plan
- Reset: hold reset for 3 cycles. All outputs are 0. Data bytes 0xF8, 0x00 -> `pix_we` with addr 0, data 0xF800. The next pair 0x07, 0xE0 -> addr 1, data 0x07E0.
- Window: send commands 0x15,0x10,0x12,0x75,0x05,0x06 -> six `cmd_valid` pulses. Then 6 pixels -> addrs 496, 497, 498, 592, 593, 594, with `frame_done` only on 594. A 7th pixel -> addr 496.
- Clamp and swap: 0x15,0x70,0x80 -> column window 95..95. 0x75,0x20,0x10 -> row window 32..32. Next pixel -> addr 3167.
- Partial byte: cs low, 5 sclk bits, cs high, then a full command byte 0xA5 -> exactly one `cmd_valid` with 0xA5.
- Protocol error: 0x15,0x10 then data byte 0xAB -> `proto_err` pulse and the window is unchanged. Following byte 0xCD -> `pix_we` with data 0xABCD at the old cursor.
- Display reset: resn low after 3 pixels of a full-screen stream, then release. The next pixel goes to addr 0 and bytes sent during resn low produce no pulses.
